// File: rtl/pc_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_branch_unit
//  Description : Program-counter sequencer fed by the ALU stage. Steps the PC,
//                resolves conditional branches on the ALU z/n/p flags, jumps
//                to ALU-computed targets, and keeps a return-address stack
//                that also saves the condition flags for restore on RET.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_branch_unit #(
  parameter int              PC_W      = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = 16'h3000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [2:0]      op,
  input  logic [2:0]      nzp_mask,
  input  logic            z,
  input  logic            n,
  input  logic            p,
  input  logic [PC_W-1:0] offset,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic            taken,
  output logic [15:0]     psr_out,
  output logic            psr_valid,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = PC_W + 3;

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_BR   = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  localparam logic [CNT_W-1:0] DEPTH_MAX = CNT_W'(RAS_DEPTH);

  // Each entry is {return address, n, z, p}.
  logic [ENT_W-1:0] r_stack [RAS_DEPTH];
  logic [CNT_W-1:0] r_depth;

  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_pc_next;
  logic [CNT_W-1:0] w_depth_dec;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_push_idx;
  logic [ENT_W-1:0] w_top;
  logic             w_cond;
  logic             w_full;
  logic             w_empty;
  logic             w_taken;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_unf_set;

  assign w_pc_inc    = pc + 1'b1;
  assign w_cond      = |(nzp_mask & {n, z, p});
  assign w_full      = (r_depth == DEPTH_MAX);
  assign w_empty     = (r_depth == '0);
  assign w_depth_dec = r_depth - 1'b1;
  assign w_top_idx   = w_depth_dec[PTR_W-1:0];
  // Only used when not full, so the low bits always address a free slot.
  assign w_push_idx  = r_depth[PTR_W-1:0];
  assign w_top       = r_stack[w_top_idx];

  assign ras_empty = w_empty;
  assign ras_full  = w_full;

  // Decode the op into the next PC and the stack/sticky side effects.
  always_comb begin
    w_pc_next = w_pc_inc;
    w_taken   = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    case (op)
      OP_BR: begin
        if (w_cond) begin
          w_pc_next = w_pc_inc + offset;
          w_taken   = 1'b1;
        end
      end
      OP_JMP: begin
        w_pc_next = target;
        w_taken   = 1'b1;
      end
      OP_CALL: begin
        w_pc_next = target;
        w_taken   = 1'b1;
        if (w_full) w_ovf_set = 1'b1;
        else        w_push    = 1'b1;
      end
      OP_RET: begin
        if (w_empty) begin
          w_unf_set = 1'b1;
        end else begin
          w_pop     = 1'b1;
          w_pc_next = w_top[ENT_W-1:3];
          w_taken   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // PC, pulses, depth counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      taken         <= 1'b0;
      psr_out       <= 16'h0000;
      psr_valid     <= 1'b0;
      r_depth       <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (en) begin
      pc        <= w_pc_next;
      taken     <= w_taken;
      psr_valid <= w_pop;
      if (w_pop) begin
        psr_out <= {13'b0, w_top[2:0]};
        r_depth <= w_depth_dec;
      end else if (w_push) begin
        r_depth <= r_depth + 1'b1;
      end
      if (w_ovf_set) ras_overflow  <= 1'b1;
      if (w_unf_set) ras_underflow <= 1'b1;
    end else begin
      taken     <= 1'b0;
      psr_valid <= 1'b0;
    end
  end

  // Stack storage; contents beyond the depth are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && en && w_push) begin
      r_stack[w_push_idx] <= {w_pc_inc, n, z, p};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_branch_unit
//  Description : Directed self-checking bench for pc_branch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  op;
  logic [2:0]  nzp_mask;
  logic        z, n, p;
  logic [15:0] offset;
  logic [15:0] target;
  logic [15:0] pc;
  logic        taken;
  logic [15:0] psr_out;
  logic        psr_valid;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  pc_branch_unit #(.PC_W(16), .RAS_DEPTH(4), .RESET_PC(16'h3000)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .nzp_mask(nzp_mask),
    .z(z), .n(n), .p(p), .offset(offset), .target(target),
    .pc(pc), .taken(taken), .psr_out(psr_out), .psr_valid(psr_valid),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply op for one rising edge, then sample 1 time unit later.
  task automatic step(input logic [2:0] o);
    op = o;
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [2:0] f);
    {n, z, p} = f;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; op = 3'b000; nzp_mask = 3'b000;
    {n, z, p} = 3'b000; offset = 16'h0; target = 16'h0;

    // Reset for two cycles
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_pc", pc, 16'h3000);
    check("rst_empty", ras_empty, 1'b1);
    check("rst_full", ras_full, 1'b0);
    check("rst_ovf", ras_overflow, 1'b0);
    check("rst_unf", ras_underflow, 1'b0);
    check("rst_taken", taken, 1'b0);
    check("rst_psrv", psr_valid, 1'b0);
    check("rst_psr", psr_out, 16'h0);
    rst = 1'b0;

    // Sequencing
    step(3'b000); step(3'b000); step(3'b000);
    check("seq3_pc", pc, 16'h3003);
    check("seq3_taken", taken, 1'b0);

    // BR taken on z: 0x3003+1-4 = 0x3000
    set_flags(3'b010); nzp_mask = 3'b010; offset = 16'hFFFC;
    step(3'b001);
    check("br_t_pc", pc, 16'h3000);
    check("br_t_taken", taken, 1'b1);

    // BR mask n with only z set: falls through
    nzp_mask = 3'b100;
    step(3'b001);
    check("br_nt_pc", pc, 16'h3001);
    check("br_nt_taken", taken, 1'b0);

    // CALL/RET round trip with flags 001
    set_flags(3'b001); target = 16'h4000;
    step(3'b011);
    check("call_pc", pc, 16'h4000);
    check("call_taken", taken, 1'b1);
    check("call_empty", ras_empty, 1'b0);
    set_flags(3'b110);
    step(3'b100);
    check("ret_pc", pc, 16'h3002);
    check("ret_psr", psr_out, 16'h0001);
    check("ret_psrv", psr_valid, 1'b1);
    check("ret_taken", taken, 1'b1);
    check("ret_empty", ras_empty, 1'b1);
    step(3'b000);
    check("seq_pc", pc, 16'h3003);
    check("psrv_pulse", psr_valid, 1'b0);
    check("psr_hold", psr_out, 16'h0001);

    // Fill stack. Pushed: 0x3004/100, 0x5001/010, 0x5002/001, 0x5003/110
    set_flags(3'b100); target = 16'h5000; step(3'b011);
    set_flags(3'b010); target = 16'h5001; step(3'b011);
    set_flags(3'b001); target = 16'h5002; step(3'b011);
    check("call3_full", ras_full, 1'b0);
    set_flags(3'b110); target = 16'h5003; step(3'b011);
    check("call4_full", ras_full, 1'b1);
    check("call4_ovf", ras_overflow, 1'b0);
    set_flags(3'b111); target = 16'h5004; step(3'b011);
    check("call5_pc", pc, 16'h5004);
    check("call5_ovf", ras_overflow, 1'b1);
    check("call5_taken", taken, 1'b1);
    check("call5_full", ras_full, 1'b1);

    // Drain in LIFO order
    set_flags(3'b000);
    step(3'b100);
    check("pop1_pc", pc, 16'h5003);
    check("pop1_psr", psr_out, 16'h0006);
    check("pop1_full", ras_full, 1'b0);
    step(3'b100);
    check("pop2_pc", pc, 16'h5002);
    check("pop2_psr", psr_out, 16'h0001);
    step(3'b100);
    check("pop3_pc", pc, 16'h5001);
    check("pop3_psr", psr_out, 16'h0002);
    step(3'b100);
    check("pop4_pc", pc, 16'h3004);
    check("pop4_psr", psr_out, 16'h0004);
    check("pop4_empty", ras_empty, 1'b1);
    step(3'b100);
    check("pop5_pc", pc, 16'h3005);
    check("pop5_unf", ras_underflow, 1'b1);
    check("pop5_taken", taken, 1'b0);
    check("pop5_psrv", psr_valid, 1'b0);
    check("pop5_psr", psr_out, 16'h0004);

    // Hold with en=0
    en = 1'b0; target = 16'h1234;
    step(3'b010); step(3'b010); step(3'b010);
    check("hold_pc", pc, 16'h3005);
    check("hold_taken", taken, 1'b0);
    check("hold_ovf", ras_overflow, 1'b1);
    en = 1'b1;

    // Push one entry, then reset on a CALL edge
    target = 16'h6000; step(3'b011);
    check("pre_rst_empty", ras_empty, 1'b0);
    rst = 1'b1; target = 16'h7000;
    step(3'b011);
    check("rstc_pc", pc, 16'h3000);
    check("rstc_empty", ras_empty, 1'b1);
    check("rstc_ovf", ras_overflow, 1'b0);
    check("rstc_unf", ras_underflow, 1'b0);
    check("rstc_taken", taken, 1'b0);
    rst = 1'b0;

    // Wrap-around
    target = 16'hFFFF; step(3'b010);
    check("jmp_pc", pc, 16'hFFFF);
    step(3'b000);
    check("wrap_seq", pc, 16'h0000);
    target = 16'hFFFE; step(3'b010);
    set_flags(3'b001); nzp_mask = 3'b111; offset = 16'h0002;
    step(3'b001);
    check("wrap_br", pc, 16'h0001);
    check("wrap_br_taken", taken, 1'b1);

    // Mask 000 never taken, reserved op acts as SEQ
    set_flags(3'b111); nzp_mask = 3'b000;
    step(3'b001);
    check("mask0_pc", pc, 16'h0002);
    check("mask0_taken", taken, 1'b0);
    step(3'b110);
    check("resv_pc", pc, 16'h0003);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
